// File: rtl/diag_pkg.sv
// Shared state encoding for the diagnostic-loop controller and future recovery controllers.
// Pure declarations: no logic, no latency, no flow control.
package diag_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    INJECT    = 3'd2,
    CIRCULATE = 3'd3,
    SAMPLE    = 3'd4,
    DONE      = 3'd5,
    ABORT_CLR = 3'd6
  } diag_state_t;

endpackage

// File: rtl/diag_fault_map.sv
// N x N fault map, written one row per cycle; rows hold until overwritten or reset.
// Write takes effect on the next clock; always accepts, no backpressure.
module diag_fault_map #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_row,
  input  logic [N-1:0]    wr_data,
  output logic [N*N-1:0]  map
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map <= '0;
    end else if (wr_en) begin
      map[int'(wr_row)*N +: N] <= wr_data;
    end
  end

endmodule

// File: rtl/diagnostic_loop_controller.sv
// Sequences one clear/inject/circulate/sample pass over the diagnostic loop chains.
// start-to-done is 2N+3 cycles; fault_vec is taken unconditionally each INJECT cycle (missing valid flags protocol_err).
module diagnostic_loop_controller
  import diag_pkg::*;
#(
  parameter  int SYSTOLIC_SIZE = 8,
  localparam int N             = SYSTOLIC_SIZE,
  localparam int CW            = $clog2(SYSTOLIC_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [N-1:0]    fault_vec,
  input  logic            fault_vec_valid,
  output logic            fault_vec_ready,
  output logic [CW-1:0]   row_idx,
  output logic            chain_rst_n,
  output logic [N-1:0]    chain_col_inputs,
  input  logic [N-1:0]    pe_detection,
  input  logic [N-1:0]    chain_col_fault,
  input  logic [N-1:0]    chain_row_fault,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            protocol_err,
  output logic [N*N-1:0]  fault_map,
  output logic [N-1:0]    col_fault,
  output logic [N-1:0]    row_fault
);

  diag_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cnt_last;
  logic          abortable;
  logic          map_wr_en;

  assign cnt_last  = (cnt == CW'(N - 1));
  assign abortable = (state == CLEAR) || (state == INJECT) ||
                     (state == CIRCULATE) || (state == SAMPLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:      if (start) state_nxt = CLEAR;
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = INJECT;
      end
      INJECT: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = CIRCULATE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CIRCULATE: begin
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SAMPLE:    state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      ABORT_CLR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // abort overrides whatever transition the active phase chose
    if (abort && abortable) begin
      state_nxt = ABORT_CLR;
      cnt_nxt   = '0;
    end
  end

  assign fault_vec_ready  = (state == INJECT);
  assign row_idx          = ((state == INJECT) || (state == CIRCULATE)) ? cnt : '0;
  assign chain_col_inputs = ((state == INJECT) && fault_vec_valid) ? fault_vec : '0;
  assign chain_rst_n      = !rst && (state != CLEAR) && (state != ABORT_CLR);
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign aborted          = (state == ABORT_CLR);

  // An abort mid-circulate keeps rows captured before the abort cycle; the abort cycle itself writes nothing.
  assign map_wr_en = (state == CIRCULATE) && !abort;

  diag_fault_map #(.N(N)) u_fault_map (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (map_wr_en),
    .wr_row  (cnt),
    .wr_data (pe_detection),
    .map     (fault_map)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err <= 1'b0;
      col_fault    <= '0;
      row_fault    <= '0;
    end else begin
      if (state == IDLE && start) begin
        protocol_err <= 1'b0;
      end else if (state == INJECT && !fault_vec_valid) begin
        protocol_err <= 1'b1;
      end
      if (state == SAMPLE && !abort) begin
        col_fault <= chain_col_fault;
        row_fault <= chain_row_fault;
      end
    end
  end

endmodule

// File: tb/tb_diagnostic_loop_controller.sv
// Directed bench for diagnostic_loop_controller with a behavioural recirculating loop-chain model.
// Expected pass results are queued at start and compared when done pulses.
module tb_diagnostic_loop_controller;

  localparam int N  = 8;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic [N-1:0]   fault_vec;
  logic           fault_vec_valid;
  logic           fault_vec_ready;
  logic [CW-1:0]  row_idx;
  logic           chain_rst_n;
  logic [N-1:0]   chain_col_inputs;
  logic [N-1:0]   pe_detection;
  logic [N-1:0]   chain_col_fault;
  logic [N-1:0]   chain_row_fault;
  logic           busy;
  logic           done;
  logic           aborted;
  logic           protocol_err;
  logic [N*N-1:0] fault_map;
  logic [N-1:0]   col_fault;
  logic [N-1:0]   row_fault;

  always #5 clk = ~clk;

  diagnostic_loop_controller #(.SYSTOLIC_SIZE(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .fault_vec        (fault_vec),
    .fault_vec_valid  (fault_vec_valid),
    .fault_vec_ready  (fault_vec_ready),
    .row_idx          (row_idx),
    .chain_rst_n      (chain_rst_n),
    .chain_col_inputs (chain_col_inputs),
    .pe_detection     (pe_detection),
    .chain_col_fault  (chain_col_fault),
    .chain_row_fault  (chain_row_fault),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .protocol_err     (protocol_err),
    .fault_map        (fault_map),
    .col_fault        (col_fault),
    .row_fault        (row_fault)
  );

  // Loop chain: N-stage recirculating row delay line; a row injected returns on pe_detection N cycles later.
  logic [N-1:0] stg [N];
  always_ff @(posedge clk or negedge chain_rst_n) begin
    if (!chain_rst_n) begin
      for (int j = 0; j < N; j++) stg[j] <= '0;
    end else begin
      stg[0] <= stg[N-1] | chain_col_inputs;
      for (int j = 1; j < N; j++) stg[j] <= stg[j-1];
    end
  end
  assign pe_detection    = stg[N-1];
  assign chain_col_fault = stg[N-1] & stg[N-2] & stg[N-3];

  logic [N-1:0] row_pat;
  assign chain_row_fault = row_pat;

  logic [N-1:0] pv  [N];
  logic         pvl [N];
  assign fault_vec       = pv[row_idx];
  assign fault_vec_valid = pvl[row_idx];

  typedef struct {
    logic [N*N-1:0] map;
    logic [N-1:0]   col;
    logic [N-1:0]   row;
    logic           perr;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  logic [N*N-1:0] last_map;
  logic [N-1:0]   last_col, last_row;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rows(input logic [N-1:0] v, input logic vl);
    for (int r = 0; r < N; r++) begin
      pv[r]  = v;
      pvl[r] = vl;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.map  = '0;
    e.col  = '1;
    e.perr = 1'b0;
    for (int r = 0; r < N; r++) begin
      e.map[r*N +: N] = pvl[r] ? pv[r] : '0;
      e.col           = e.col & e.map[r*N +: N];
      if (!pvl[r]) e.perr = 1'b1;
    end
    e.row = row_pat;
    sb.push_back(e);
  endtask

  // Start a pass at a negedge, wait for done, then compare against the queued expectation.
  task automatic run_pass(input string tag, input logic hold);
    int   lat;
    exp_t e;
    lat = -1;
    push_exp();
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(2*N+3));
    e = sb.pop_front();
    check({tag, "_fault_map"}, fault_map, e.map);
    check({tag, "_col_fault"}, 64'(col_fault), 64'(e.col));
    check({tag, "_row_fault"}, 64'(row_fault), 64'(e.row));
    check({tag, "_protocol_err"}, 64'(protocol_err), 64'(e.perr));
    last_map = e.map;
    last_col = e.col;
    last_row = e.row;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_idle_after_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int found;
    int seen_done;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    row_pat = '0;
    set_rows('0, 1'b1);

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_chain_rst_n", 64'(chain_rst_n), 64'd0);
    check("rst_fault_map", fault_map, 64'd0);
    check("rst_ready", 64'(fault_vec_ready), 64'd0);
    check("rst_perr", 64'(protocol_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_chain_rst_n", 64'(chain_rst_n), 64'd1);
    check("idle_row_idx", 64'(row_idx), 64'd0);

    // 1: all-zero pass
    run_pass("t1_zero", 1'b0);

    // 2: single fault in row 2
    set_rows('0, 1'b1);
    pv[2]   = 8'h10;
    row_pat = 8'hA5;
    run_pass("t2_row2", 1'b0);
    check("t2_row2_bits", fault_map[23:16], 64'h10);

    // 3: column 0 faulty everywhere
    set_rows(8'h01, 1'b1);
    row_pat = 8'h00;
    run_pass("t3_col0", 1'b0);
    check("t3_col_fault0", 64'(col_fault[0]), 64'd1);

    // 4: missing valid on row 5
    set_rows('0, 1'b1);
    pv[0]  = 8'h80;
    pv[5]  = 8'hFF;
    pvl[5] = 1'b0;
    run_pass("t4_noval", 1'b0);
    check("t4_row5_zero", fault_map[47:40], 64'h0);
    repeat (3) @(negedge clk);
    check("t4_perr_sticky", 64'(protocol_err), 64'd1);

    // abort while idle is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_pulse", 64'(aborted), 64'd0);

    // 5: abort during injection of row 3
    set_rows(8'hFF, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_perr_cleared", 64'(protocol_err), 64'd0);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (fault_vec_ready === 1'b1 && row_idx === 3'd3) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reach_row3", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_aborted", 64'(aborted), 64'd1);
    check("t5_chain_rst", 64'(chain_rst_n), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t5_aborted_pulse", 64'(aborted), 64'd0);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_chain_release", 64'(chain_rst_n), 64'd1);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check("t5_no_done", 64'(seen_done), 64'd0);
    check("t5_map_kept", fault_map, last_map);
    check("t5_col_kept", 64'(col_fault), 64'(last_col));
    check("t5_row_kept", 64'(row_fault), 64'(last_row));

    // 6: start held through a pass, then reset mid-circulate of the re-armed pass
    set_rows('0, 1'b1);
    pv[7]   = 8'h42;
    row_pat = 8'h3C;
    run_pass("t6_held", 1'b1);
    @(negedge clk);
    check("t6_rearm", 64'(busy), 64'd1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b1 && fault_vec_ready === 1'b0 && row_idx === 3'd4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reach_circ", 64'(found), 64'd1);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_map", fault_map, 64'd0);
    check("t6_rst_col", 64'(col_fault), 64'd0);
    check("t6_rst_row", 64'(row_fault), 64'd0);
    check("t6_rst_chain", 64'(chain_rst_n), 64'd0);
    check("t6_rst_row_idx", 64'(row_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_rst_idle", 64'(busy), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
